// File: rtl/uart_param.sv
// Parameterised UART: one TX frame per tx_ack, with back-to-back frames while tx_req is held.
// RX samples each bit mid-cell, and a new frame overwrites unread data with rx_ovr set.
module uart_param #(
  parameter int    DATA_BITS    = 8,
  parameter string PARITY       = "NONE",
  parameter int    STOP_BITS    = 1,
  parameter int    CLKS_PER_BIT = 16
) (
  input  logic                 inclk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_req,
  output logic                 tx_ack,
  output logic                 tx_busy,
  output logic                 txd,
  input  logic                 rxd,
  input  logic                 loopback,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_rdy,
  input  logic                 rx_ack,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_ovr
);

  localparam bit              PAR_EN   = (PARITY != "NONE");
  localparam bit              PAR_ODD  = (PARITY == "ODD");
  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]      DATA_END = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_END = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]           tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_ack_c;
  logic                 tx_line;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = (tx_cnt_q == BIT_END) ? '0 : tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_ack_c   = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_ack_c = tx_req & ~rst;
      end
      S_START: if (tx_cnt_q == BIT_END) tx_state_d = S_DATA;
      S_DATA: if (tx_cnt_q == BIT_END) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == DATA_END) begin
          tx_bit_d   = '0;
          tx_state_d = PAR_EN ? S_PAR : S_STOP;
        end else begin
          tx_bit_d = tx_bit_q + 4'd1;
        end
      end
      S_PAR: if (tx_cnt_q == BIT_END) tx_state_d = S_STOP;
      S_STOP: if (tx_cnt_q == BIT_END) begin
        if (tx_bit_q == STOP_END) begin
          tx_state_d = S_IDLE;
          // Accepting on the last stop cycle keeps a held request gap-free.
          tx_ack_c   = tx_req & ~rst;
        end else begin
          tx_bit_d = tx_bit_q + 4'd1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (tx_ack_c) begin
      tx_shift_d = tx_data;
      tx_par_d   = (^tx_data) ^ PAR_ODD;
      tx_bit_d   = '0;
      tx_state_d = S_START;
    end
  end

  always_comb begin
    case (tx_state_q)
      S_START: tx_line = 1'b0;
      S_DATA:  tx_line = tx_shift_q[0];
      S_PAR:   tx_line = tx_par_q;
      default: tx_line = 1'b1;
    endcase
  end

  assign txd     = tx_line;
  assign tx_ack  = tx_ack_c;
  assign tx_busy = (tx_state_q != S_IDLE);

  always_ff @(posedge inclk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  logic [1:0]           sync_q;
  logic                 rx_prev_q;
  logic                 rx_line;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_end;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_rdy_q, rx_rdy_d, rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d, rx_ovr_q, rx_ovr_d;

  assign rx_line = sync_q[1];

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = (rx_cnt_q == BIT_END) ? '0 : rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_end     = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_line) rx_state_d = S_START;
      end
      S_START: if (rx_cnt_q == HALF_END) begin
        // A line back high at mid-start is a glitch, not a frame.
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_par_d   = 1'b0;
        rx_state_d = rx_line ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == BIT_END) begin
        rx_shift_d = {rx_line, rx_shift_q[DATA_BITS-1:1]};
        rx_par_d   = rx_par_q ^ rx_line;
        rx_bit_d   = rx_bit_q + 4'd1;
        if (rx_bit_q == DATA_END) rx_state_d = PAR_EN ? S_PAR : S_STOP;
      end
      S_PAR: if (rx_cnt_q == BIT_END) begin
        rx_par_d   = rx_par_q ^ rx_line;
        rx_state_d = S_STOP;
      end
      S_STOP: if (rx_cnt_q == BIT_END) begin
        rx_end     = 1'b1;
        rx_state_d = S_IDLE;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_data_d = rx_data_q;
    rx_rdy_d  = rx_rdy_q;
    rx_perr_d = rx_perr_q;
    rx_ferr_d = rx_ferr_q;
    rx_ovr_d  = rx_ovr_q;
    if (rx_end) begin
      rx_data_d = rx_shift_q;
      rx_rdy_d  = 1'b1;
      rx_perr_d = PAR_EN && (rx_par_q != PAR_ODD);
      rx_ferr_d = ~rx_line;
      rx_ovr_d  = (rx_rdy_q | rx_ovr_q) & ~rx_ack;
    end else if (rx_ack) begin
      rx_rdy_d  = 1'b0;
      rx_perr_d = 1'b0;
      rx_ferr_d = 1'b0;
      rx_ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge inclk) begin
    if (rst) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_rdy_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], loopback ? tx_line : rxd};
      rx_prev_q  <= rx_line;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_rdy_q   <= rx_rdy_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rx_rdy  = rx_rdy_q;
  assign rx_perr = rx_perr_q;
  assign rx_ferr = rx_ferr_q;
  assign rx_ovr  = rx_ovr_q;

endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param: ODD loopback (a), EVEN driven rxd (b), 9-bit/2-stop/NONE loopback (c).
module tb_uart_param;

  logic inclk = 1'b0;
  logic rst;
  always #5 inclk = ~inclk;

  int vecs = 0;
  int errs = 0;

  logic [7:0] a_tx_data, a_rx_data;
  logic a_tx_req, a_tx_ack, a_tx_busy, a_txd, a_rxd, a_loop, a_rx_rdy, a_rx_ack, a_perr, a_ferr, a_ovr;
  logic [7:0] b_tx_data, b_rx_data;
  logic b_tx_req, b_tx_ack, b_tx_busy, b_txd, b_rxd, b_loop, b_rx_rdy, b_rx_ack, b_perr, b_ferr, b_ovr;
  logic [8:0] c_tx_data, c_rx_data;
  logic c_tx_req, c_tx_ack, c_tx_busy, c_txd, c_rxd, c_loop, c_rx_rdy, c_rx_ack, c_perr, c_ferr, c_ovr;

  uart_param #(.DATA_BITS(8), .PARITY("ODD"), .STOP_BITS(1), .CLKS_PER_BIT(16)) dut_a (
    .inclk(inclk), .rst(rst), .tx_data(a_tx_data), .tx_req(a_tx_req), .tx_ack(a_tx_ack),
    .tx_busy(a_tx_busy), .txd(a_txd), .rxd(a_rxd), .loopback(a_loop), .rx_data(a_rx_data),
    .rx_rdy(a_rx_rdy), .rx_ack(a_rx_ack), .rx_perr(a_perr), .rx_ferr(a_ferr), .rx_ovr(a_ovr));

  uart_param #(.DATA_BITS(8), .PARITY("EVEN"), .STOP_BITS(1), .CLKS_PER_BIT(16)) dut_b (
    .inclk(inclk), .rst(rst), .tx_data(b_tx_data), .tx_req(b_tx_req), .tx_ack(b_tx_ack),
    .tx_busy(b_tx_busy), .txd(b_txd), .rxd(b_rxd), .loopback(b_loop), .rx_data(b_rx_data),
    .rx_rdy(b_rx_rdy), .rx_ack(b_rx_ack), .rx_perr(b_perr), .rx_ferr(b_ferr), .rx_ovr(b_ovr));

  uart_param #(.DATA_BITS(9), .PARITY("NONE"), .STOP_BITS(2), .CLKS_PER_BIT(16)) dut_c (
    .inclk(inclk), .rst(rst), .tx_data(c_tx_data), .tx_req(c_tx_req), .tx_ack(c_tx_ack),
    .tx_busy(c_tx_busy), .txd(c_txd), .rxd(c_rxd), .loopback(c_loop), .rx_data(c_rx_data),
    .rx_rdy(c_rx_rdy), .rx_ack(c_rx_ack), .rx_perr(c_perr), .rx_ferr(c_ferr), .rx_ovr(c_ovr));

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  // Serial frame on b_rxd: start, 8 data LSB first, parity bit p, one stop bit s, then 16 idle cycles.
  task automatic drive_rx_b(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      b_rxd = f[k];
      repeat (16) tick();
    end
    b_rxd = 1'b1;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_tx_req = 1'b1; a_tx_data = 8'h5A;
    repeat (2) tick();
    #1;
    vecs++;
    if (a_tx_ack !== 1'b0) begin errs++; $display("FAIL reset_tx_ack got=%b exp=0", a_tx_ack); end
    vecs++;
    if ({a_txd, a_tx_busy, a_rx_rdy, a_perr, a_ferr, a_ovr} !== 6'b100000) begin
      errs++; $display("FAIL reset_a_flags got=%b exp=100000", {a_txd, a_tx_busy, a_rx_rdy, a_perr, a_ferr, a_ovr});
    end
    vecs++;
    if ({b_txd, b_tx_busy, b_rx_rdy, b_perr, b_ferr, b_ovr} !== 6'b100000) begin
      errs++; $display("FAIL reset_b_flags got=%b exp=100000", {b_txd, b_tx_busy, b_rx_rdy, b_perr, b_ferr, b_ovr});
    end
    vecs++;
    if ({c_txd, c_tx_busy, c_rx_rdy, c_perr, c_ferr, c_ovr} !== 6'b100000) begin
      errs++; $display("FAIL reset_c_flags got=%b exp=100000", {c_txd, c_tx_busy, c_rx_rdy, c_perr, c_ferr, c_ovr});
    end
    vecs++;
    if ({a_rx_data, b_rx_data, c_rx_data} !== 25'd0) begin
      errs++; $display("FAIL reset_rx_data got=%h/%h/%h exp=0", a_rx_data, b_rx_data, c_rx_data);
    end
    rst = 1'b0; a_tx_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_odd_frame();
    logic [10:0] fa;
    fa = 11'h7FE;
    a_tx_data = 8'hFF; a_tx_req = 1'b1;
    #1;
    vecs++;
    if (a_tx_ack !== 1'b1) begin errs++; $display("FAIL odd_tx_ack got=%b exp=1", a_tx_ack); end
    tick();
    a_tx_req = 1'b0;
    #1;
    vecs++;
    if ({a_tx_ack, a_tx_busy} !== 2'b01) begin errs++; $display("FAIL odd_ack_busy got=%b exp=01", {a_tx_ack, a_tx_busy}); end
    for (int i = 0; i < 176; i++) begin
      if (i > 0) tick();
      vecs++;
      if (a_txd !== fa[i/16]) begin errs++; $display("FAIL odd_txd cycle=%0d got=%b exp=%b", i, a_txd, fa[i/16]); end
    end
    tick();
    vecs++;
    if ({a_txd, a_tx_busy} !== 2'b10) begin errs++; $display("FAIL odd_idle got=%b exp=10", {a_txd, a_tx_busy}); end
    vecs++;
    if ({a_rx_rdy, a_perr, a_ferr, a_ovr} !== 4'b1000) begin
      errs++; $display("FAIL odd_rx_flags got=%b exp=1000", {a_rx_rdy, a_perr, a_ferr, a_ovr});
    end
    vecs++;
    if (a_rx_data !== 8'hFF) begin errs++; $display("FAIL odd_rx_data got=%h exp=ff", a_rx_data); end
    a_rx_ack = 1'b1;
    tick();
    a_rx_ack = 1'b0;
    vecs++;
    if (a_rx_rdy !== 1'b0) begin errs++; $display("FAIL odd_rx_ack_clear got=%b exp=0", a_rx_rdy); end
  endtask

  task automatic test_back_to_back();
    int sent, got, last_ack;
    logic step;
    logic [7:0] exp_w [4];
    exp_w[0] = 8'h01; exp_w[1] = 8'h03; exp_w[2] = 8'h05; exp_w[3] = 8'h07;
    sent = 0; got = 0; last_ack = -1; step = 1'b0;
    a_tx_data = 8'h01; a_tx_req = 1'b1;
    for (int cyc = 0; cyc < 4 * 176 + 100 && got < 4; cyc++) begin
      if (step) begin
        a_tx_data = a_tx_data + 8'd2;
        step = 1'b0;
        if (sent == 4) a_tx_req = 1'b0;
      end
      a_rx_ack = 1'b0;
      #1;
      if (a_tx_ack) begin
        if (sent > 0) begin
          vecs++;
          if (cyc - last_ack != 176 || a_tx_busy !== 1'b1) begin
            errs++; $display("FAIL b2b_gap frame=%0d interval=%0d busy=%b exp=176/1", sent, cyc - last_ack, a_tx_busy);
          end
        end
        last_ack = cyc;
        sent++;
        step = 1'b1;
      end
      if (a_rx_rdy) begin
        vecs++;
        if (a_rx_data !== exp_w[got]) begin errs++; $display("FAIL b2b_word idx=%0d got=%h exp=%h", got, a_rx_data, exp_w[got]); end
        got++;
        a_rx_ack = 1'b1;
      end
      tick();
    end
    a_tx_req = 1'b0; a_rx_ack = 1'b0;
    vecs++;
    if (got != 4 || sent != 4) begin errs++; $display("FAIL b2b_count got=%0d sent=%0d exp=4/4", got, sent); end
    repeat (30) tick();
  endtask

  task automatic test_parity_err();
    drive_rx_b(8'h03, 1'b1, 1'b1);
    vecs++;
    if ({b_rx_rdy, b_perr, b_ferr, b_ovr} !== 4'b1100) begin
      errs++; $display("FAIL perr_flags got=%b exp=1100", {b_rx_rdy, b_perr, b_ferr, b_ovr});
    end
    vecs++;
    if (b_rx_data !== 8'h03) begin errs++; $display("FAIL perr_data got=%h exp=03", b_rx_data); end
    b_rx_ack = 1'b1; tick(); b_rx_ack = 1'b0;
    vecs++;
    if ({b_rx_rdy, b_perr} !== 2'b00) begin errs++; $display("FAIL perr_clear got=%b exp=00", {b_rx_rdy, b_perr}); end
  endtask

  task automatic test_frame_err();
    drive_rx_b(8'h55, 1'b0, 1'b0);
    vecs++;
    if ({b_rx_rdy, b_perr, b_ferr, b_ovr} !== 4'b1010) begin
      errs++; $display("FAIL ferr_flags got=%b exp=1010", {b_rx_rdy, b_perr, b_ferr, b_ovr});
    end
    vecs++;
    if (b_rx_data !== 8'h55) begin errs++; $display("FAIL ferr_data got=%h exp=55", b_rx_data); end
    b_rx_ack = 1'b1; tick(); b_rx_ack = 1'b0;
    vecs++;
    if ({b_rx_rdy, b_ferr} !== 2'b00) begin errs++; $display("FAIL ferr_clear got=%b exp=00", {b_rx_rdy, b_ferr}); end
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    b_rxd = 1'b0;
    repeat (5) tick();
    b_rxd = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (b_rx_rdy) seen = 1'b1;
    end
    vecs++;
    if (seen !== 1'b0) begin errs++; $display("FAIL glitch_rdy got=%b exp=0", seen); end
    drive_rx_b(8'hC3, 1'b0, 1'b1);
    vecs++;
    if ({b_rx_rdy, b_perr, b_ferr, b_rx_data} !== {3'b100, 8'hC3}) begin
      errs++; $display("FAIL glitch_recover got=%b%b%b/%h exp=100/c3", b_rx_rdy, b_perr, b_ferr, b_rx_data);
    end
    b_rx_ack = 1'b1; tick(); b_rx_ack = 1'b0;
  endtask

  task automatic test_overrun();
    drive_rx_b(8'hA5, 1'b0, 1'b1);
    drive_rx_b(8'h3C, 1'b0, 1'b1);
    vecs++;
    if ({b_rx_rdy, b_perr, b_ferr, b_ovr} !== 4'b1001) begin
      errs++; $display("FAIL ovr_flags got=%b exp=1001", {b_rx_rdy, b_perr, b_ferr, b_ovr});
    end
    vecs++;
    if (b_rx_data !== 8'h3C) begin errs++; $display("FAIL ovr_data got=%h exp=3c", b_rx_data); end
    b_rx_ack = 1'b1; tick(); b_rx_ack = 1'b0;
    vecs++;
    if ({b_rx_rdy, b_perr, b_ferr, b_ovr} !== 4'b0000) begin
      errs++; $display("FAIL ovr_clear got=%b exp=0000", {b_rx_rdy, b_perr, b_ferr, b_ovr});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic seen;
    seen = 1'b0;
    a_tx_data = 8'h00; a_tx_req = 1'b1;
    tick();
    a_tx_req = 1'b0;
    repeat (56) tick();
    vecs++;
    if ({a_txd, a_tx_busy} !== 2'b01) begin errs++; $display("FAIL midrst_pre got=%b exp=01", {a_txd, a_tx_busy}); end
    rst = 1'b1;
    tick();
    vecs++;
    if ({a_txd, a_tx_busy} !== 2'b10) begin errs++; $display("FAIL midrst_abort got=%b exp=10", {a_txd, a_tx_busy}); end
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (a_rx_rdy || a_tx_busy) seen = 1'b1;
    end
    vecs++;
    if (seen !== 1'b0) begin errs++; $display("FAIL midrst_partial got=%b exp=0", seen); end
  endtask

  task automatic test_nine_bit();
    logic [11:0] fc;
    fc = 12'hF4A;
    c_tx_data = 9'h1A5; c_tx_req = 1'b1;
    #1;
    vecs++;
    if (c_tx_ack !== 1'b1) begin errs++; $display("FAIL nine_tx_ack got=%b exp=1", c_tx_ack); end
    tick();
    c_tx_req = 1'b0;
    for (int i = 0; i < 192; i++) begin
      if (i > 0) tick();
      vecs++;
      if (c_txd !== fc[i/16]) begin errs++; $display("FAIL nine_txd cycle=%0d got=%b exp=%b", i, c_txd, fc[i/16]); end
    end
    tick();
    vecs++;
    if ({c_txd, c_tx_busy} !== 2'b10) begin errs++; $display("FAIL nine_idle got=%b exp=10", {c_txd, c_tx_busy}); end
    vecs++;
    if ({c_rx_rdy, c_perr, c_ferr, c_ovr} !== 4'b1000 || c_rx_data !== 9'h1A5) begin
      errs++; $display("FAIL nine_rx got=%b/%h exp=1000/1a5", {c_rx_rdy, c_perr, c_ferr, c_ovr}, c_rx_data);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_tx_data = '0; a_tx_req = 1'b0; a_rxd = 1'b1; a_loop = 1'b1; a_rx_ack = 1'b0;
    b_tx_data = '0; b_tx_req = 1'b0; b_rxd = 1'b1; b_loop = 1'b0; b_rx_ack = 1'b0;
    c_tx_data = '0; c_tx_req = 1'b0; c_rxd = 1'b1; c_loop = 1'b1; c_rx_ack = 1'b0;
    test_reset();
    test_odd_frame();
    test_back_to_back();
    test_parity_err();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
    test_nine_bit();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
